regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
- REQ-001 SHALL have parameters (name, default, meaning): XLEN, 32, data width (multiple of 8); NREGS, 32, register count (power of 2, >=2); AW, $clog2(NREGS), address width; DSP_BASE, 16, first DSP-visible register; NDSP, 3, number of DSP-visible registers; BYPASS, 1, 1 = write-first read forwarding, 0 = read-old.
- REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; rst_n in 1 asynchronous active-low reset.
- REQ-003 SHALL have: rs1_addr, rs2_addr in AW read addresses; rs1_data, rs2_data out XLEN read data; rs1_busy, rs2_busy out 1 operand pending.
- REQ-004 SHALL have: wr_en in 1 core write; wr_addr in AW; wr_be in XLEN/8 byte enables; wr_data in XLEN.
- REQ-005 SHALL have: rsv_en in 1 reserve destination for DSP result; rsv_addr in AW.
- REQ-006 SHALL have: dsp_wb_valid in 1; dsp_wb_ready out 1; dsp_wb_addr in AW; dsp_wb_data in XLEN (DSP write-back handshake).
- REQ-007 SHALL have: dsp_regs out NDSP*XLEN, register DSP_BASE+k at bits [k*XLEN +: XLEN]; sb_pending out NREGS scoreboard bits.

Function
- REQ-008 Register 0 SHALL read 0, ignore all writes, never be reserved; sb_pending[0] SHALL be constant 0.
- REQ-009 Reads SHALL be combinational from stored array, zero added latency.
- REQ-010 Core write SHALL commit at posedge when wr_en=1 and wr_addr!=0, updating only bytes with wr_be[i]=1; wr_be=0 SHALL leave register unchanged.
- REQ-011 DSP write SHALL commit full word at posedge when dsp_wb_valid && dsp_wb_ready and dsp_wb_addr!=0.
- REQ-012 dsp_wb_ready SHALL be rst_n && !(wr_en && wr_addr==dsp_wb_addr && wr_addr!=0); core port has priority on same-address conflict; differing addresses SHALL both commit in one cycle.
- REQ-013 DSP producer SHALL hold valid/addr/data stable until accepted; block SHALL not drop a stalled write.
- REQ-014 BYPASS=1: read of address matching an enabled core write (addr!=0) SHALL return stored word with wr_be bytes replaced by wr_data; else matching an accepted DSP write SHALL return dsp_wb_data; else stored value. BYPASS=0: always stored value.
- REQ-015 rsv_en with rsv_addr!=0 SHALL set sb_pending[rsv_addr] at next posedge; accepted DSP write SHALL clear sb_pending[dsp_wb_addr]; same-cycle set and clear of same address SHALL leave bit set.
- REQ-016 Core writes SHALL NOT modify sb_pending.
- REQ-017 rsN_busy SHALL equal sb_pending[rsN_addr], forced 0 when BYPASS=1 and an accepted DSP write targets rsN_addr that cycle.
- REQ-018 dsp_regs SHALL reflect stored values only (no bypass), updating the cycle after commit.
- REQ-019 Elaboration SHALL fail if DSP_BASE+NDSP>NREGS, DSP_BASE==0, or XLEN%8!=0.

Reset
- REQ-020 rst_n low SHALL asynchronously clear all registers, sb_pending, dsp_regs to 0; rs*_data SHALL read 0, rs*_busy 0, dsp_wb_ready 0.
- REQ-021 Writes/reservations presented while rst_n low SHALL be discarded; a reset mid DSP handshake SHALL drop that write and its reservation.
- REQ-022 First posedge after rst_n rises SHALL accept writes normally.

Verification
- REQ-023 Reset, then core write r5=0xDEADBEEF wr_be=4'hF, next cycle rs1_addr=5 -> rs1_data=0xDEADBEEF; write r0=0x1234 -> rs1_addr=0 reads 0.
- REQ-024 r7=0x11223344, then wr_be=4'b0101 wr_data=0xAABBCCDD -> r7=0x11BB33DD; same cycle rs2_addr=7 with BYPASS=1 -> 0x11BB33DD, BYPASS=0 -> 0x11223344.
- REQ-025 rsv_en addr 17 -> sb_pending[17]=1, rs1_busy=1 for rs1_addr=17; DSP wb 17=0x55 -> accepted, rs1_data=0x55, rs1_busy=0 same cycle (BYPASS=1), dsp_regs[63:32]=0x55 next cycle.
- REQ-026 Same-cycle core write r16=0x1 and DSP wb r16=0x2 -> dsp_wb_ready=0, r16=0x1; next cycle ready=1, r16=0x2 after commit; core r3 + DSP r4 same cycle -> both commit.
- REQ-027 rsv_en r18 and accepted DSP wb r18 same cycle -> r18=data, sb_pending[18] stays 1.
- REQ-028 rst_n pulled low mid-cycle during DSP valid to r16 with pending set -> immediately all regs 0, sb_pending=0, dsp_wb_ready=0; after release r16 remains 0.

Source files
------------

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-port register file with byte-enabled core write port,
//                DSP write-back handshake port, per-register pending
//                scoreboard and a flat view of the DSP-visible registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int DSP_BASE = 16,
    parameter int NDSP     = 3,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // read ports
    input  logic [AW-1:0]        rs1_addr,
    input  logic [AW-1:0]        rs2_addr,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    // core write port
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [XLEN/8-1:0]    wr_be,
    input  logic [XLEN-1:0]      wr_data,
    // destination reservation
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    // DSP write-back handshake
    input  logic                 dsp_wb_valid,
    output logic                 dsp_wb_ready,
    input  logic [AW-1:0]        dsp_wb_addr,
    input  logic [XLEN-1:0]      dsp_wb_data,
    // observation
    output logic [NDSP*XLEN-1:0] dsp_regs,
    output logic [NREGS-1:0]     sb_pending
);

    localparam int c_NBYTES = XLEN / 8;

    // Parameter sanity: refuse to elaborate an inconsistent configuration.
    generate
        if (DSP_BASE + NDSP > NREGS) begin : g_chk_dsp_range
            $error("regfile_mp: DSP_BASE+NDSP exceeds NREGS");
        end
        if (DSP_BASE == 0) begin : g_chk_dsp_base
            $error("regfile_mp: DSP_BASE must not be 0");
        end
        if (XLEN % 8 != 0) begin : g_chk_xlen
            $error("regfile_mp: XLEN must be a multiple of 8");
        end
    endgenerate

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pending;

    logic             w_core_we;
    logic             w_dsp_we;
    logic             w_rsv_we;
    logic [XLEN-1:0]  w_core_merged;
    logic [AW-1:0]    w_raddr [2];
    logic [XLEN-1:0]  w_rdata [2];
    logic             w_rbusy [2];

    // Core port wins a same-address conflict; the DSP producer simply waits.
    assign dsp_wb_ready = rst_n && !(wr_en && (wr_addr == dsp_wb_addr) && (wr_addr != '0));
    assign w_core_we    = rst_n && wr_en && (wr_addr != '0);
    assign w_dsp_we     = dsp_wb_valid && dsp_wb_ready && (dsp_wb_addr != '0);
    assign w_rsv_we     = rst_n && rsv_en && (rsv_addr != '0);

    // Stored word at the core write address with the enabled bytes replaced.
    always_comb begin
        w_core_merged = r_regs[wr_addr];
        for (int b = 0; b < c_NBYTES; b++) begin
            if (wr_be[b]) begin
                w_core_merged[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    assign w_raddr[0] = rs1_addr;
    assign w_raddr[1] = rs2_addr;

    // Read ports: stored value, optionally forwarded from this cycle's writes.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = r_regs[w_raddr[p]];
            w_rbusy[p] = r_pending[w_raddr[p]];
            if (BYPASS != 0) begin
                if (w_core_we && (wr_addr == w_raddr[p])) begin
                    w_rdata[p] = w_core_merged;
                end else if (w_dsp_we && (dsp_wb_addr == w_raddr[p])) begin
                    w_rdata[p] = dsp_wb_data;
                end
                if (w_dsp_we && (dsp_wb_addr == w_raddr[p])) begin
                    w_rbusy[p] = 1'b0;
                end
            end
        end
    end

    assign rs1_data = w_rdata[0];
    assign rs2_data = w_rdata[1];
    assign rs1_busy = w_rbusy[0];
    assign rs2_busy = w_rbusy[1];

    // Register array update; entry 0 is never written and stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_core_we && (wr_addr == AW'(i))) begin
                    r_regs[i] <= w_core_merged;
                end else if (w_dsp_we && (dsp_wb_addr == AW'(i))) begin
                    r_regs[i] <= dsp_wb_data;
                end
            end
        end
    end

    // Scoreboard: a new reservation overrides a same-cycle write-back clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_rsv_we && (rsv_addr == AW'(i))) begin
                    r_pending[i] <= 1'b1;
                end else if (w_dsp_we && (dsp_wb_addr == AW'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    assign sb_pending = r_pending;

    // Flat, unforwarded view of the DSP-visible registers.
    generate
        for (genvar k = 0; k < NDSP; k++) begin : g_dsp_view
            assign dsp_regs[k*XLEN +: XLEN] = r_regs[DSP_BASE + k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp. Two instances (forwarding
//                and read-old) share stimulus; a reference model predicts all
//                outputs into a queue that is drained when outputs are sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, rsv_addr, dsp_wb_addr;
    logic            wr_en, rsv_en, dsp_wb_valid;
    logic [3:0]      wr_be;
    logic [XLEN-1:0] wr_data, dsp_wb_data;

    logic [XLEN-1:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
    logic            b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy;
    logic            b_ready, n_ready;
    logic [95:0]     b_dsp_regs, n_dsp_regs;
    logic [31:0]     b_pend, n_pend;

    regfile_mp #(.BYPASS(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .dsp_wb_valid(dsp_wb_valid), .dsp_wb_ready(b_ready),
        .dsp_wb_addr(dsp_wb_addr), .dsp_wb_data(dsp_wb_data),
        .dsp_regs(b_dsp_regs), .sb_pending(b_pend)
    );

    regfile_mp #(.BYPASS(0)) u_dut_n (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
        .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .dsp_wb_valid(dsp_wb_valid), .dsp_wb_ready(n_ready),
        .dsp_wb_addr(dsp_wb_addr), .dsp_wb_data(dsp_wb_data),
        .dsp_regs(n_dsp_regs), .sb_pending(n_pend)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [XLEN-1:0]  mregs [NREGS];
    logic [NREGS-1:0] mpend;
    logic             m_cwe, m_ready, m_dacc;
    logic [XLEN-1:0]  m_merged;

    typedef struct {
        logic [31:0] rs1b, rs2b, rs1n, rs2n;
        logic        bsy1b, bsy2b, bsy1n, bsy2n, ready;
        logic [31:0] pend;
        logic [95:0] dspr;
    } exp_t;
    exp_t sbq[$];

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;
        mpend = '0;
    endtask

    function automatic logic [31:0] mread(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && m_cwe && a == wr_addr) return m_merged;
        if (byp && m_dacc && a == dsp_wb_addr) return dsp_wb_data;
        return mregs[a];
    endfunction

    function automatic logic mbusy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && m_dacc && a == dsp_wb_addr) return 1'b0;
        return mpend[a];
    endfunction

    task automatic predict();
        exp_t e;
        logic [31:0] old;
        m_cwe   = rst_n && wr_en && wr_addr != 0;
        m_ready = rst_n && !(wr_en && wr_addr == dsp_wb_addr && wr_addr != 0);
        m_dacc  = dsp_wb_valid && m_ready && dsp_wb_addr != 0;
        old = mregs[wr_addr];
        for (int b = 0; b < 4; b++) m_merged[b*8 +: 8] = wr_be[b] ? wr_data[b*8 +: 8] : old[b*8 +: 8];
        e.rs1b  = mread(rs1_addr, 1'b1);  e.rs2b  = mread(rs2_addr, 1'b1);
        e.rs1n  = mread(rs1_addr, 1'b0);  e.rs2n  = mread(rs2_addr, 1'b0);
        e.bsy1b = mbusy(rs1_addr, 1'b1);  e.bsy2b = mbusy(rs2_addr, 1'b1);
        e.bsy1n = mbusy(rs1_addr, 1'b0);  e.bsy2n = mbusy(rs2_addr, 1'b0);
        e.ready = m_ready;
        e.pend  = mpend;
        e.dspr  = {mregs[18], mregs[17], mregs[16]};
        sbq.push_back(e);
    endtask

    task automatic commit();
        if (!rst_n) begin
            model_clear();
        end else begin
            if (m_cwe) mregs[wr_addr] = m_merged;
            if (m_dacc) begin
                mregs[dsp_wb_addr] = dsp_wb_data;
                mpend[dsp_wb_addr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) mpend[rsv_addr] = 1'b1;
        end
    endtask

    task automatic compare_sb();
        exp_t e;
        if (sbq.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard: queue empty, got nothing expected one entry");
            return;
        end
        e = sbq.pop_front();
        chk("b_rs1_data", b_rs1_data, e.rs1b);  chk("b_rs2_data", b_rs2_data, e.rs2b);
        chk("n_rs1_data", n_rs1_data, e.rs1n);  chk("n_rs2_data", n_rs2_data, e.rs2n);
        chk("b_rs1_busy", b_rs1_busy, e.bsy1b); chk("b_rs2_busy", b_rs2_busy, e.bsy2b);
        chk("n_rs1_busy", n_rs1_busy, e.bsy1n); chk("n_rs2_busy", n_rs2_busy, e.bsy2n);
        chk("b_ready", b_ready, e.ready);       chk("n_ready", n_ready, e.ready);
        chk("b_sb_pending", b_pend, e.pend);    chk("n_sb_pending", n_pend, e.pend);
        chk("b_dsp_regs", b_dsp_regs, e.dspr);  chk("n_dsp_regs", n_dsp_regs, e.dspr);
    endtask

    task automatic end_cycle();
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    task automatic run_cycle();
        predict();
        #2;
        compare_sb();
        end_cycle();
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_be = 0; wr_data = 0;
        rsv_en = 0; rsv_addr = 0;
        dsp_wb_valid = 0; dsp_wb_addr = 0; dsp_wb_data = 0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic we; logic [4:0] wa; logic [3:0] be; logic [31:0] wd;
        logic rv; logic [4:0] ra;
        logic dv; logic [4:0] da; logic [31:0] dd;
        logic [4:0] a1, a2;
        logic [31:0] e1, e2b, e2n; logic eb1, erdy;
    } vec_t;
    localparam int NVEC = 21;
    vec_t tbl [NVEC];

    task automatic row(input int i, input logic we, input logic [4:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic rv, input logic [4:0] ra,
                       input logic dv, input logic [4:0] da, input logic [31:0] dd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] e1,
                       input logic [31:0] e2b, input logic [31:0] e2n, input logic eb1,
                       input logic erdy);
        tbl[i].we = we; tbl[i].wa = wa; tbl[i].be = be; tbl[i].wd = wd;
        tbl[i].rv = rv; tbl[i].ra = ra;
        tbl[i].dv = dv; tbl[i].da = da; tbl[i].dd = dd;
        tbl[i].a1 = a1; tbl[i].a2 = a2;
        tbl[i].e1 = e1; tbl[i].e2b = e2b; tbl[i].e2n = e2n; tbl[i].eb1 = eb1; tbl[i].erdy = erdy;
    endtask

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(15, 18));
        return 5'($urandom_range(0, 31));
    endfunction

    bit hold;

    initial begin
        //   i  we wa  be    wd           rv ra  dv da  dd     a1  a2  e1           e2b          e2n          b1 rdy
        row( 0, 1, 5, 4'hF, 32'hDEADBEEF, 0, 0,  0, 0,  0,     5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,       0, 1);
        row( 1, 0, 0, 4'h0, 32'h0,        0, 0,  0, 0,  0,     5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1);
        row( 2, 1, 0, 4'hF, 32'h1234,     0, 0,  0, 0,  0,     0,  0,  32'h0,        32'h0,        32'h0,       0, 1);
        row( 3, 0, 0, 4'h0, 32'h0,        0, 0,  0, 0,  0,     0,  5,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 1);
        row( 4, 1, 7, 4'hF, 32'h11223344, 0, 0,  0, 0,  0,     7,  5,  32'h11223344, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1);
        row( 5, 1, 7, 4'h5, 32'hAABBCCDD, 0, 0,  0, 0,  0,     7,  7,  32'h11BB33DD, 32'h11BB33DD, 32'h11223344, 0, 1);
        row( 6, 0, 0, 4'h0, 32'h0,        0, 0,  0, 0,  0,     7,  7,  32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 0, 1);
        row( 7, 1, 7, 4'h0, 32'hFFFFFFFF, 0, 0,  0, 0,  0,     7,  7,  32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 0, 1);
        row( 8, 0, 0, 4'h0, 32'h0,        1, 17, 0, 0,  0,     17, 17, 32'h0,        32'h0,        32'h0,       0, 1);
        row( 9, 0, 0, 4'h0, 32'h0,        0, 0,  0, 0,  0,     17, 17, 32'h0,        32'h0,        32'h0,       1, 1);
        row(10, 0, 0, 4'h0, 32'h0,        0, 0,  1, 17, 32'h55, 17, 17, 32'h55,       32'h55,       32'h0,       0, 1);
        row(11, 0, 0, 4'h0, 32'h0,        0, 0,  0, 0,  0,     17, 17, 32'h55,       32'h55,       32'h55,      0, 1);
        row(12, 1, 16, 4'hF, 32'h1,       0, 0,  1, 16, 32'h2, 16, 16, 32'h1,        32'h1,        32'h0,       0, 0);
        row(13, 0, 0, 4'h0, 32'h0,        0, 0,  1, 16, 32'h2, 16, 16, 32'h2,        32'h2,        32'h1,       0, 1);
        row(14, 0, 0, 4'h0, 32'h0,        0, 0,  0, 0,  0,     16, 16, 32'h2,        32'h2,        32'h2,       0, 1);
        row(15, 1, 3, 4'hF, 32'h33,       0, 0,  1, 4,  32'h44, 3,  4,  32'h33,       32'h44,       32'h0,       0, 1);
        row(16, 0, 0, 4'h0, 32'h0,        0, 0,  0, 0,  0,     3,  4,  32'h33,       32'h44,       32'h44,      0, 1);
        row(17, 0, 0, 4'h0, 32'h0,        1, 18, 1, 18, 32'h77, 18, 18, 32'h77,       32'h77,       32'h0,       0, 1);
        row(18, 0, 0, 4'h0, 32'h0,        0, 0,  0, 0,  0,     18, 18, 32'h77,       32'h77,       32'h77,      1, 1);
        row(19, 0, 0, 4'h0, 32'h0,        1, 16, 0, 0,  0,     16, 16, 32'h2,        32'h2,        32'h2,       0, 1);
        row(20, 0, 0, 4'h0, 32'h0,        0, 0,  0, 0,  0,     16, 16, 32'h2,        32'h2,        32'h2,       1, 1);

        model_clear();
        idle_inputs();
        rs1_addr = 0; rs2_addr = 0;
        @(negedge clk);

        // Reset state; a write presented during reset must be discarded.
        wr_en = 1; wr_addr = 5; wr_be = 4'hF; wr_data = 32'hCAFEF00D; rs1_addr = 5; rs2_addr = 5;
        run_cycle();
        idle_inputs();
        rst_n = 1'b1;
        run_cycle();

        // Directed vectors.
        for (int i = 0; i < NVEC; i++) begin
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_be = tbl[i].be; wr_data = tbl[i].wd;
            rsv_en = tbl[i].rv; rsv_addr = tbl[i].ra;
            dsp_wb_valid = tbl[i].dv; dsp_wb_addr = tbl[i].da; dsp_wb_data = tbl[i].dd;
            rs1_addr = tbl[i].a1; rs2_addr = tbl[i].a2;
            predict();
            #2;
            compare_sb();
            chk($sformatf("vec%0d_rs1_data", i), b_rs1_data, tbl[i].e1);
            chk($sformatf("vec%0d_rs2_data_fwd", i), b_rs2_data, tbl[i].e2b);
            chk($sformatf("vec%0d_rs2_data_old", i), n_rs2_data, tbl[i].e2n);
            chk($sformatf("vec%0d_rs1_busy", i), b_rs1_busy, tbl[i].eb1);
            chk($sformatf("vec%0d_ready", i), b_ready, tbl[i].erdy);
            end_cycle();
        end

        // Reset asserted mid-cycle during a DSP write-back to a pending register.
        idle_inputs();
        dsp_wb_valid = 1; dsp_wb_addr = 16; dsp_wb_data = 32'h99;
        rs1_addr = 16; rs2_addr = 5;
        predict();
        #1;
        compare_sb();
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_rs1_data", b_rs1_data, 32'h0);
        chk("midrst_rs2_data", b_rs2_data, 32'h0);
        chk("midrst_rs1_busy", b_rs1_busy, 1'b0);
        chk("midrst_ready", b_ready, 1'b0);
        chk("midrst_sb_pending", b_pend, 32'h0);
        chk("midrst_dsp_regs", b_dsp_regs, 96'h0);
        chk("midrst_n_rs2_data", n_rs2_data, 32'h0);
        end_cycle();
        rst_n = 1'b1;
        dsp_wb_valid = 0;
        wr_en = 1; wr_addr = 9; wr_be = 4'hF; wr_data = 32'hABCD1234;
        rs1_addr = 16; rs2_addr = 9;
        run_cycle();
        idle_inputs();
        rs1_addr = 9; rs2_addr = 16;
        run_cycle();

        // Randomised traffic honouring the hold-until-accepted rule.
        hold = 0;
        for (int c = 0; c < 400; c++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = pick_addr();
            wr_be   = 4'($urandom);
            wr_data = $urandom;
            rsv_en  = ($urandom_range(0, 3) == 0);
            rsv_addr = pick_addr();
            if (!hold) begin
                dsp_wb_valid = ($urandom_range(0, 9) < 4);
                dsp_wb_addr  = pick_addr();
                dsp_wb_data  = $urandom;
            end
            rs1_addr = pick_addr();
            rs2_addr = pick_addr();
            run_cycle();
            hold = dsp_wb_valid && !m_ready;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
